backing_ram_responder: RTL and testbench

BACKING_RAM_RESPONDER -- requirements
Module: backing_ram_responder

---
 rtl/backing_ram_responder_pkg.sv | 18 +
 rtl/backing_ram_responder_ram_array.sv | 37 +++
 rtl/backing_ram_responder.sv | 119 +++++++++++
 tb/tb_backing_ram_responder.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/backing_ram_responder_pkg.sv
// Shared CPU package: FSM state encoding, RAM-select bit index and default
// response latency used by the backing RAM responder and its RAM array.
package backing_ram_responder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // Register-space address bit that selects the RAM window.
  localparam int unsigned RAM_SEL_BIT     = 4;
  localparam int unsigned DEFAULT_LATENCY = 2;
  localparam int unsigned ADDR_W          = 5;
  localparam int unsigned IDX_W           = 4;
  localparam int unsigned DATA_W          = 32;

endpackage

// File: rtl/backing_ram_responder_ram_array.sv
// ram_array: DEPTH x 32 word store with synchronous write and asynchronous
// read. On reset every word i is loaded with 16+i, the register-space
// address of that word.
//   CLK   - clock
//   RESET - synchronous active-low reset
//   WE    - write enable
//   ADDR  - word index (shared by read and write)
//   WDATA - write data
//   RDATA - combinational read data at ADDR
module ram_array
  import backing_ram_responder_pkg::*;
#(
  parameter int unsigned DEPTH = 16
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              WE,
  input  logic [IDX_W-1:0]  ADDR,
  input  logic [DATA_W-1:0] WDATA,
  output logic [DATA_W-1:0] RDATA
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= DATA_W'(16 + i);
      end
    end else if (WE) begin
      mem[ADDR] <= WDATA;
    end
  end

  assign RDATA = mem[ADDR];

endmodule

// File: rtl/backing_ram_responder.sv
// backing_ram_responder: single-outstanding request/response front end for a
// small RAM window in register space. A request is accepted in IDLE, waits
// LATENCY cycles in BUSY, executes on the final BUSY edge and is presented in
// RESP until consumed. Addresses with bit 4 clear are answered with an error.
//   CLK        - clock
//   RESET      - synchronous active-low reset
//   REQ_VALID  - request present
//   REQ_READY  - responder idle and able to accept
//   REQ_WE     - 1 = write, 0 = read
//   REQ_ADDR   - register-space address (bit 4 selects RAM)
//   REQ_WDATA  - write data
//   RSP_VALID  - response available
//   RSP_READY  - requester consumes response
//   RSP_RDATA  - read data (0 for writes and errors)
//   RSP_ERR    - request addressed non-RAM space
module backing_ram_responder
  import backing_ram_responder_pkg::*;
#(
  parameter int unsigned LATENCY = DEFAULT_LATENCY,
  parameter int unsigned DEPTH   = 16
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              REQ_VALID,
  output logic              REQ_READY,
  input  logic              REQ_WE,
  input  logic [ADDR_W-1:0] REQ_ADDR,
  input  logic [DATA_W-1:0] REQ_WDATA,
  output logic              RSP_VALID,
  input  logic              RSP_READY,
  output logic [DATA_W-1:0] RSP_RDATA,
  output logic              RSP_ERR
);

  state_t              state, state_nxt;
  logic [3:0]          cnt;
  logic                cap_we;
  logic [ADDR_W-1:0]   cap_addr;
  logic [DATA_W-1:0]   cap_wdata;
  logic [DATA_W-1:0]   rdata_q;
  logic                err_q;
  logic                execute;
  logic                sel;
  logic                ram_we;
  logic [DATA_W-1:0]   ram_rdata;

  assign sel    = cap_addr[RAM_SEL_BIT];
  assign ram_we = execute & cap_we & sel;

  ram_array #(.DEPTH(DEPTH)) u_ram (
    .CLK   (CLK),
    .RESET (RESET),
    .WE    (ram_we),
    .ADDR  (cap_addr[IDX_W-1:0]),
    .WDATA (cap_wdata),
    .RDATA (ram_rdata)
  );

  always_ff @(posedge CLK) begin
    if (!RESET) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    REQ_READY = 1'b0;
    RSP_VALID = 1'b0;
    RSP_RDATA = '0;
    RSP_ERR   = 1'b0;
    execute   = 1'b0;
    case (state)
      ST_IDLE: begin
        REQ_READY = 1'b1;
        if (REQ_VALID) state_nxt = ST_BUSY;
      end
      ST_BUSY: begin
        if (cnt == 4'd0) begin
          execute   = 1'b1;
          state_nxt = ST_RESP;
        end
      end
      ST_RESP: begin
        RSP_VALID = 1'b1;
        RSP_RDATA = rdata_q;
        RSP_ERR   = err_q;
        if (RSP_READY) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Capture, latency count and response registers. The RAM also resets on
  // RESET=0, so an aborted write can never land.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      cnt       <= '0;
      cap_we    <= 1'b0;
      cap_addr  <= '0;
      cap_wdata <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      if (state == ST_IDLE && REQ_VALID) begin
        cap_we    <= REQ_WE;
        cap_addr  <= REQ_ADDR;
        cap_wdata <= REQ_WDATA;
        cnt       <= 4'(LATENCY - 1);
      end
      if (state == ST_BUSY && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
      if (execute) begin
        rdata_q <= (sel && !cap_we) ? ram_rdata : '0;
        err_q   <= ~sel;
      end
    end
  end

endmodule

// File: tb/tb_backing_ram_responder.sv
module tb_backing_ram_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n     [3];
  logic        req_valid [3];
  logic        req_ready [3];
  logic        req_we    [3];
  logic [4:0]  req_addr  [3];
  logic [31:0] req_wdata [3];
  logic        rsp_valid [3];
  logic        rsp_ready [3];
  logic [31:0] rsp_rdata [3];
  logic        rsp_err   [3];

  backing_ram_responder #(.LATENCY(2), .DEPTH(16)) u_lat2 (
    .CLK(clk), .RESET(rst_n[0]), .REQ_VALID(req_valid[0]), .REQ_READY(req_ready[0]),
    .REQ_WE(req_we[0]), .REQ_ADDR(req_addr[0]), .REQ_WDATA(req_wdata[0]),
    .RSP_VALID(rsp_valid[0]), .RSP_READY(rsp_ready[0]), .RSP_RDATA(rsp_rdata[0]),
    .RSP_ERR(rsp_err[0]));

  backing_ram_responder #(.LATENCY(1), .DEPTH(16)) u_lat1 (
    .CLK(clk), .RESET(rst_n[1]), .REQ_VALID(req_valid[1]), .REQ_READY(req_ready[1]),
    .REQ_WE(req_we[1]), .REQ_ADDR(req_addr[1]), .REQ_WDATA(req_wdata[1]),
    .RSP_VALID(rsp_valid[1]), .RSP_READY(rsp_ready[1]), .RSP_RDATA(rsp_rdata[1]),
    .RSP_ERR(rsp_err[1]));

  backing_ram_responder #(.LATENCY(15), .DEPTH(16)) u_lat15 (
    .CLK(clk), .RESET(rst_n[2]), .REQ_VALID(req_valid[2]), .REQ_READY(req_ready[2]),
    .REQ_WE(req_we[2]), .REQ_ADDR(req_addr[2]), .REQ_WDATA(req_wdata[2]),
    .RSP_VALID(rsp_valid[2]), .RSP_READY(rsp_ready[2]), .RSP_RDATA(rsp_rdata[2]),
    .RSP_ERR(rsp_err[2]));

  int checks = 0;
  int errors = 0;
  logic [31:0] model [3][16];

  function automatic int lat_of(input int k);
    case (k)
      0:       return 2;
      1:       return 1;
      default: return 15;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset(input int k);
    for (int i = 0; i < 16; i++) model[k][i] = 32'(16 + i);
  endtask

  task automatic garbage(input int k);
    req_valid[k] = 1'($urandom_range(0, 1));
    req_we[k]    = 1'($urandom_range(0, 1));
    req_addr[k]  = 5'($urandom_range(0, 31));
    req_wdata[k] = $urandom();
  endtask

  task automatic check_idle_outputs(input int k, input string tag);
    check({tag, "_req_ready"}, 32'(req_ready[k]), 32'd1);
    check({tag, "_rsp_valid"}, 32'(rsp_valid[k]), 32'd0);
    check({tag, "_rsp_rdata"}, rsp_rdata[k], 32'd0);
    check({tag, "_rsp_err"},   32'(rsp_err[k]), 32'd0);
  endtask

  task automatic do_reset(input int k);
    rst_n[k] = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n[k] = 1'b1;
    model_reset(k);
    check_idle_outputs(k, "reset");
  endtask

  // One complete request/response exchange; caller sits at a negedge.
  task automatic txn(input int k, input logic we, input logic [4:0] addr,
                     input logic [31:0] wd, input int hold);
    int n;
    logic [31:0] er;
    logic ee;
    n = 0;
    while (req_ready[k] !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("req_ready_wait", 32'(req_ready[k]), 32'd1);
    ee = ~addr[4];
    er = (addr[4] && !we) ? model[k][addr[3:0]] : 32'd0;
    if (addr[4] && we) model[k][addr[3:0]] = wd;
    req_valid[k] = 1'b1;
    req_we[k]    = we;
    req_addr[k]  = addr;
    req_wdata[k] = wd;
    @(posedge clk);
    n = 0;
    @(negedge clk);
    garbage(k);
    rsp_ready[k] = 1'($urandom_range(0, 1));
    while (rsp_valid[k] !== 1'b1 && n < 40) begin
      check("busy_rsp_rdata", rsp_rdata[k], 32'd0);
      check("busy_rsp_err",   32'(rsp_err[k]), 32'd0);
      check("busy_req_ready", 32'(req_ready[k]), 32'd0);
      @(posedge clk);
      n++;
      @(negedge clk);
      garbage(k);
      rsp_ready[k] = 1'($urandom_range(0, 1));
    end
    check("latency",   32'(n), 32'(lat_of(k)));
    check("rsp_rdata", rsp_rdata[k], er);
    check("rsp_err",   32'(rsp_err[k]), 32'(ee));
    rsp_ready[k] = 1'b0;
    for (int h = 0; h < hold; h++) begin
      @(posedge clk);
      @(negedge clk);
      garbage(k);
      check("hold_rsp_valid", 32'(rsp_valid[k]), 32'd1);
      check("hold_rsp_rdata", rsp_rdata[k], er);
      check("hold_rsp_err",   32'(rsp_err[k]), 32'(ee));
      check("hold_req_ready", 32'(req_ready[k]), 32'd0);
    end
    req_valid[k] = 1'b0;
    rsp_ready[k] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready[k] = 1'b0;
    check_idle_outputs(k, "bubble");
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int k = 0; k < 3; k++) begin
      rst_n[k] = 1'b0;  req_valid[k] = 1'b0; req_we[k] = 1'b0;
      req_addr[k] = '0; req_wdata[k] = '0;   rsp_ready[k] = 1'b0;
    end
    repeat (2) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      check_idle_outputs(k, "init_reset");
      rst_n[k] = 1'b1;
      model_reset(k);
    end

    // Basic read, write-then-read, error space.
    txn(0, 1'b0, 5'h13, 32'd0, 0);
    txn(0, 1'b1, 5'h15, 32'hDEADBEEF, 0);
    txn(0, 1'b0, 5'h15, 32'd0, 0);
    txn(0, 1'b0, 5'h03, 32'd0, 0);
    txn(0, 1'b1, 5'h03, 32'hCAFEF00D, 0);
    for (int i = 0; i < 16; i++) txn(0, 1'b0, 5'(16 + i), 32'd0, 0);

    // Response held off for 5 cycles with stray request pulses.
    txn(0, 1'b0, 5'h1A, 32'd0, 5);
    txn(0, 1'b0, 5'h1B, 32'd0, 0);

    // Reset while a write to 0x1F is in flight.
    req_valid[0] = 1'b1; req_we[0] = 1'b1; req_addr[0] = 5'h1F; req_wdata[0] = 32'd1;
    @(posedge clk);
    @(negedge clk);
    req_valid[0] = 1'b0;
    rst_n[0] = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n[0] = 1'b1;
    model_reset(0);
    check_idle_outputs(0, "abort");
    repeat (4) begin
      @(posedge clk);
      @(negedge clk);
      check("abort_no_rsp", 32'(rsp_valid[0]), 32'd0);
    end
    txn(0, 1'b0, 5'h1F, 32'd0, 0);

    // Randomized traffic against the model.
    repeat (40) txn(0, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
                    $urandom(), int'($urandom_range(0, 3)));
    do_reset(0);
    repeat (10) txn(0, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
                    $urandom(), int'($urandom_range(0, 2)));

    // Latency extremes with back-to-back traffic.
    for (int k = 1; k < 3; k++) begin
      repeat (8) txn(k, 1'b0, {1'b1, 4'($urandom_range(0, 15))}, 32'd0, 0);
      repeat (6) txn(k, 1'($urandom_range(0, 1)), {1'b1, 4'($urandom_range(0, 15))},
                     $urandom(), 0);
      repeat (4) txn(k, 1'b0, {1'b1, 4'($urandom_range(0, 15))}, 32'd0, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
